// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of fetch-time prediction metadata, resolved at ID
// against actual outcomes to drive predictor updates and misprediction redirects.
// Optional performance counters are compiled in with `define BRU_PERF_CNT_EN.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [31:0]              if_pc,
    input  logic                     if_pred_taken,
    input  logic [31:0]              if_pred_target,
    input  logic [1:0]               if_pred_state,
    input  logic                     id_valid,
    input  logic                     id_is_branch,
    input  logic                     id_taken,
    input  logic [31:0]              id_target,
    output logic                     q_full,
    output logic                     update_en,
    output logic                     branch_taken,
    output logic [31:0]              resolved_pc,
    output logic [31:0]              resolved_target,
    output logic [1:0]               resolved_state,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic                     flush,
    output logic                     underflow_err,
    output logic                     dbg_state,
    output logic [$clog2(DEPTH):0]   dbg_count
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]         branch_cnt,
    output logic [CNT_W-1:0]         mispredict_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
        $error("branch_resolve_unit: DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
    end

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic [31:0] pc_mem     [DEPTH];
    logic        taken_mem  [DEPTH];
    logic [31:0] target_mem [DEPTH];
    logic [1:0]  state_mem  [DEPTH];

    logic        update_en_q;
    logic        branch_taken_q;
    logic [31:0] resolved_pc_q;
    logic [31:0] resolved_target_q;
    logic [1:0]  resolved_state_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic        flush_q;
    logic        underflow_q;

    logic        in_run;
    logic        full;
    logic        pop;
    logic        enq;
    logic        mispredict_now;
    logic        underflow_now;
    logic [31:0] h_pc;
    logic        h_taken;
    logic [31:0] h_target;
    logic [1:0]  h_state;
    logic [31:0] next_pc;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_RUN;
        else     state_q <= state_d;
    end

    // FSM next state: FLUSH always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (mispredict_now) state_d = S_FLUSH;
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_run    = (state_q == S_RUN);
        dbg_state = state_q;
    end

    assign full     = (count_q == CW'(DEPTH));
    assign h_pc     = pc_mem[head_q];
    assign h_taken  = taken_mem[head_q];
    assign h_target = target_mem[head_q];
    assign h_state  = state_mem[head_q];

    always_comb begin
        pop            = in_run && id_valid && (count_q != '0);
        underflow_now  = in_run && id_valid && (count_q == '0);
        mispredict_now = 1'b0;
        if (pop) begin
            if (id_is_branch)
                mispredict_now = (h_taken != id_taken) ||
                                 (h_taken && id_taken && (h_target != id_target));
            else
                mispredict_now = h_taken;
        end
        // A same-cycle pop frees the head slot, so a full queue still accepts the enqueue.
        enq     = in_run && if_valid && (!full || pop) && !mispredict_now;
        next_pc = (id_is_branch && id_taken) ? id_target : h_pc + 32'd4;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict_now) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) head_d = head_q + PTR_W'(1);
            if (enq) tail_d = tail_q + PTR_W'(1);
            count_d = count_q + CW'(enq) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail_q]     <= if_pc;
            taken_mem[tail_q]  <= if_pred_taken;
            target_mem[tail_q] <= if_pred_target;
            state_mem[tail_q]  <= if_pred_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            update_en_q       <= 1'b0;
            branch_taken_q    <= 1'b0;
            resolved_pc_q     <= '0;
            resolved_target_q <= '0;
            resolved_state_q  <= '0;
            redirect_valid_q  <= 1'b0;
            redirect_pc_q     <= '0;
            flush_q           <= 1'b0;
            underflow_q       <= 1'b0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            update_en_q      <= pop && id_is_branch;
            redirect_valid_q <= mispredict_now;
            flush_q          <= mispredict_now;
            if (pop && id_is_branch) begin
                branch_taken_q    <= id_taken;
                resolved_pc_q     <= h_pc;
                resolved_target_q <= id_target;
                resolved_state_q  <= h_state;
            end
            if (mispredict_now) redirect_pc_q <= next_pc;
            if (underflow_now)  underflow_q   <= 1'b1;
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispredict_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (pop && id_is_branch) branch_cnt_q     <= branch_cnt_q + CNT_W'(1);
            if (mispredict_now)      mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`endif

    assign q_full          = full;
    assign update_en       = update_en_q;
    assign branch_taken    = branch_taken_q;
    assign resolved_pc     = resolved_pc_q;
    assign resolved_target = resolved_target_q;
    assign resolved_state  = resolved_state_q;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign flush           = flush_q;
    assign underflow_err   = underflow_q;
    assign dbg_count       = count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed vectors checked with immediate assertions.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic [1:0]  if_pred_state;
    logic        id_valid;
    logic        id_is_branch;
    logic        id_taken;
    logic [31:0] id_target;
    logic        q_full;
    logic        update_en;
    logic        branch_taken;
    logic [31:0] resolved_pc;
    logic [31:0] resolved_target;
    logic [1:0]  resolved_state;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        underflow_err;
    logic        dbg_state;
    logic [2:0]  dbg_count;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;
`endif

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.DEPTH(4), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_pred_taken   (if_pred_taken),
        .if_pred_target  (if_pred_target),
        .if_pred_state   (if_pred_state),
        .id_valid        (id_valid),
        .id_is_branch    (id_is_branch),
        .id_taken        (id_taken),
        .id_target       (id_target),
        .q_full          (q_full),
        .update_en       (update_en),
        .branch_taken    (branch_taken),
        .resolved_pc     (resolved_pc),
        .resolved_target (resolved_target),
        .resolved_state  (resolved_state),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .underflow_err   (underflow_err),
        .dbg_state       (dbg_state),
        .dbg_count       (dbg_count)
`ifdef BRU_PERF_CNT_EN
        ,
        .branch_cnt      (branch_cnt),
        .mispredict_cnt  (mispredict_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic set_enq(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                           input logic [1:0] st);
        if_valid       = 1'b1;
        if_pc          = pc;
        if_pred_taken  = pt;
        if_pred_target = tgt;
        if_pred_state  = st;
    endtask

    task automatic set_pop(input logic br, input logic tk, input logic [31:0] tgt);
        id_valid     = 1'b1;
        id_is_branch = br;
        id_taken     = tk;
        id_target    = tgt;
    endtask

    task automatic clear_in();
        if_valid       = 1'b0;
        if_pc          = '0;
        if_pred_taken  = 1'b0;
        if_pred_target = '0;
        if_pred_state  = '0;
        id_valid       = 1'b0;
        id_is_branch   = 1'b0;
        id_taken       = 1'b0;
        id_target      = '0;
    endtask

    task automatic enq(input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                       input logic [1:0] st);
        set_enq(pc, pt, tgt, st);
        tick();
        clear_in();
    endtask

    task automatic pop(input logic br, input logic tk, input logic [31:0] tgt);
        set_pop(br, tk, tgt);
        tick();
        clear_in();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_in();
        do_reset();

        // reset state
        chk("rst_update_en", 32'(update_en), 32'd0);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_q_full", 32'(q_full), 32'd0);
        chk("rst_underflow", 32'(underflow_err), 32'd0);
        chk("rst_count", 32'(dbg_count), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);

        // correct not-taken
        enq(32'h100, 1'b0, 32'h0, 2'b01);
        chk("t1_count", 32'(dbg_count), 32'd1);
        pop(1'b1, 1'b0, 32'h0);
        chk("t1_update_en", 32'(update_en), 32'd1);
        chk("t1_branch_taken", 32'(branch_taken), 32'd0);
        chk("t1_resolved_pc", resolved_pc, 32'h100);
        chk("t1_resolved_state", 32'(resolved_state), 32'd1);
        chk("t1_redirect", 32'(redirect_valid), 32'd0);
        tick();
        chk("t1_update_drop", 32'(update_en), 32'd0);
        chk("t1_pc_hold", resolved_pc, 32'h100);

        // direction mispredict
        enq(32'h200, 1'b0, 32'h0, 2'b01);
        enq(32'h204, 1'b0, 32'h0, 2'b00);
        enq(32'h208, 1'b0, 32'h0, 2'b00);
        chk("t2_count3", 32'(dbg_count), 32'd3);
        pop(1'b1, 1'b1, 32'h400);
        chk("t2_redirect", 32'(redirect_valid), 32'd1);
        chk("t2_redirect_pc", redirect_pc, 32'h400);
        chk("t2_flush", 32'(flush), 32'd1);
        chk("t2_update_en", 32'(update_en), 32'd1);
        chk("t2_branch_taken", 32'(branch_taken), 32'd1);
        chk("t2_count0", 32'(dbg_count), 32'd0);
        chk("t2_state_flush", 32'(dbg_state), 32'd1);
        tick();
        chk("t2_redirect_drop", 32'(redirect_valid), 32'd0);
        chk("t2_flush_drop", 32'(flush), 32'd0);
        chk("t2_update_drop", 32'(update_en), 32'd0);
        chk("t2_state_run", 32'(dbg_state), 32'd0);

        // target mispredict
        enq(32'h300, 1'b1, 32'h500, 2'b11);
        pop(1'b1, 1'b1, 32'h600);
        chk("t3_redirect", 32'(redirect_valid), 32'd1);
        chk("t3_redirect_pc", redirect_pc, 32'h600);
        chk("t3_resolved_target", resolved_target, 32'h600);
        chk("t3_resolved_state", 32'(resolved_state), 32'd3);
        tick();

        // BTB alias on a non-branch
        enq(32'h310, 1'b1, 32'h999, 2'b10);
        pop(1'b0, 1'b0, 32'h0);
        chk("t3_alias_redirect", 32'(redirect_valid), 32'd1);
        chk("t3_alias_pc", redirect_pc, 32'h314);
        chk("t3_alias_update", 32'(update_en), 32'd0);
        chk("t3_alias_res_pc_hold", resolved_pc, 32'h300);
        tick();

        // correctly predicted taken
        enq(32'h320, 1'b1, 32'h700, 2'b10);
        pop(1'b1, 1'b1, 32'h700);
        chk("t3_ok_update", 32'(update_en), 32'd1);
        chk("t3_ok_redirect", 32'(redirect_valid), 32'd0);
        chk("t3_ok_target", resolved_target, 32'h700);
        tick();

        // full queue and pointer wrap
        for (int k = 0; k < 4; k++) enq(32'h1000 + 32'(4 * k), 1'b0, 32'h0, 2'(k));
        chk("t4_full", 32'(q_full), 32'd1);
        chk("t4_count4", 32'(dbg_count), 32'd4);
        enq(32'hDEAD, 1'b0, 32'h0, 2'b00);
        chk("t4_blocked_count", 32'(dbg_count), 32'd4);
        for (int k = 4; k < 10; k++) begin
            set_enq(32'h1000 + 32'(4 * k), 1'b0, 32'h0, 2'(k));
            set_pop(1'b1, 1'b0, 32'h0);
            tick();
            clear_in();
            chk("t4_stream_pc", resolved_pc, 32'h1000 + 32'(4 * (k - 4)));
            chk("t4_stream_count", 32'(dbg_count), 32'd4);
        end
        for (int k = 6; k < 10; k++) begin
            pop(1'b1, 1'b0, 32'h0);
            chk("t4_drain_pc", resolved_pc, 32'h1000 + 32'(4 * k));
            chk("t4_drain_state", 32'(resolved_state), 32'(k % 4));
        end
        chk("t4_empty", 32'(dbg_count), 32'd0);
        chk("t4_no_redirect", 32'(redirect_valid), 32'd0);

        // pop from empty queue
        pop(1'b1, 1'b0, 32'h0);
        chk("t5_underflow", 32'(underflow_err), 32'd1);
        chk("t5_underflow_noupd", 32'(update_en), 32'd0);
        tick();
        chk("t5_underflow_sticky", 32'(underflow_err), 32'd1);

        // enqueue dropped alongside a mispredict pop
        enq(32'h2000, 1'b0, 32'h0, 2'b00);
        set_enq(32'h2004, 1'b0, 32'h0, 2'b00);
        set_pop(1'b1, 1'b1, 32'h3000);
        tick();
        clear_in();
        chk("t5_drop_redirect_pc", redirect_pc, 32'h3000);
        chk("t5_drop_count", 32'(dbg_count), 32'd0);
        tick();
        chk("t5_drop_count_after", 32'(dbg_count), 32'd0);

        // reset during FLUSH
        enq(32'h2100, 1'b1, 32'h2200, 2'b10);
        pop(1'b1, 1'b0, 32'h0);
        chk("t5_pre_rst_redirect", 32'(redirect_valid), 32'd1);
        chk("t5_pre_rst_pc", redirect_pc, 32'h2104);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_redirect", 32'(redirect_valid), 32'd0);
        chk("t5_rst_flush", 32'(flush), 32'd0);
        chk("t5_rst_update", 32'(update_en), 32'd0);
        chk("t5_rst_redirect_pc", redirect_pc, 32'd0);
        chk("t5_rst_resolved_pc", resolved_pc, 32'd0);
        chk("t5_rst_underflow", 32'(underflow_err), 32'd0);
        chk("t5_rst_state", 32'(dbg_state), 32'd0);

`ifdef BRU_PERF_CNT_EN
        // counters: 3 branches (1 mispredicted) plus 1 alias
        do_reset();
        enq(32'h4000, 1'b0, 32'h0, 2'b01);
        pop(1'b1, 1'b0, 32'h0);
        enq(32'h4010, 1'b0, 32'h0, 2'b01);
        pop(1'b1, 1'b1, 32'h4800);
        tick();
        enq(32'h4800, 1'b1, 32'h4900, 2'b11);
        pop(1'b1, 1'b1, 32'h4900);
        enq(32'h4900, 1'b1, 32'h5000, 2'b10);
        pop(1'b0, 1'b0, 32'h0);
        tick();
        chk("t6_branch_cnt", branch_cnt, 32'd3);
        chk("t6_mispredict_cnt", mispredict_cnt, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
